// File: rtl/eco_patch_sim_ctrl.sv
// eco_patch_sim_ctrl: exhaustive pattern sequencer comparing a patched cone against its golden copy
module eco_patch_sim_ctrl #(
    parameter int N_IN   = 3,
    parameter int N_OUT  = 1,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            stop_on_fail,
    output logic [N_IN-1:0] vec,
    input  logic [N_OUT-1:0] impl_o,
    input  logic [N_OUT-1:0] gold_o,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   mismatch_cnt,
    output logic [N_IN-1:0] first_fail,
    output logic            fail_seen
);
    typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;
    localparam logic [3:0] LAST = 4'(SETTLE - 1);
    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [N_IN-1:0] vec_q, vec_d, ff_q, ff_d;
    logic [N_IN:0]   mc_q, mc_d;
    logic            fs_q, fs_d, pass_q, pass_d, sof_q, sof_d;
    logic            miss;
    assign miss = impl_o != gold_o;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        ff_d    = ff_q;
        mc_d    = mc_q;
        fs_d    = fs_q;
        pass_d  = pass_q;
        sof_d   = sof_q;
        unique case (state_q)
            IDLE: if (start) begin
                state_d = APPLY;
                cnt_d   = '0;
                vec_d   = '0;
                ff_d    = '0;
                mc_d    = '0;
                fs_d    = 1'b0;
                pass_d  = 1'b0;
                sof_d   = stop_on_fail;
            end
            APPLY: begin
                state_d = abort ? IDLE : (cnt_q == LAST ? CHECK : APPLY);
                cnt_d   = cnt_q == LAST ? 4'd0 : cnt_q + 4'd1;
            end
            CHECK: if (abort) begin
                state_d = IDLE;
            end else begin
                // mc_d already carries this check's update, so pass reflects the final pattern
                mc_d   = miss ? mc_q + (N_IN+1)'(1) : mc_q;
                ff_d   = miss && !fs_q ? vec_q : ff_q;
                fs_d   = fs_q | miss;
                if (vec_q == '1 || (sof_q && miss)) begin
                    state_d = DONE;
                    pass_d  = mc_d == '0;
                end else begin
                    state_d = APPLY;
                    vec_d   = vec_q + N_IN'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            ff_q    <= '0;
            mc_q    <= '0;
            fs_q    <= 1'b0;
            pass_q  <= 1'b0;
            sof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            ff_q    <= ff_d;
            mc_q    <= mc_d;
            fs_q    <= fs_d;
            pass_q  <= pass_d;
            sof_q   <= sof_d;
        end
    end
    assign vec          = vec_q;
    assign busy         = state_q == APPLY || state_q == CHECK;
    assign done         = state_q == DONE;
    assign pass         = pass_q;
    assign mismatch_cnt = mc_q;
    assign first_fail   = ff_q;
    assign fail_seen    = fs_q;
endmodule

// File: tb/tb_eco_patch_sim_ctrl.sv
// tb_eco_patch_sim_ctrl: random and directed runs on two sequencers (SETTLE 1 and 3) against a pattern-level model
module tb_eco_patch_sim_ctrl;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, sof = 1'b0;
    logic [7:0] tt_i = 8'h00, tt_g = 8'h00;
    logic [2:0] vec_a, vec_b, ff_a, ff_b;
    logic [3:0] mc_a, mc_b;
    logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b, fs_a, fs_b;
    logic       imp_a, gol_a, imp_b, gol_b;
    int cyc = 0, checks = 0, errors = 0;

    assign imp_a = tt_i[vec_a];
    assign gol_a = tt_g[vec_a];
    assign imp_b = tt_i[vec_b];
    assign gol_b = tt_g[vec_b];

    eco_patch_sim_ctrl #(.N_IN(3), .N_OUT(1), .SETTLE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stop_on_fail(sof),
        .vec(vec_a), .impl_o(imp_a), .gold_o(gol_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .mismatch_cnt(mc_a), .first_fail(ff_a), .fail_seen(fs_a));
    eco_patch_sim_ctrl #(.N_IN(3), .N_OUT(1), .SETTLE(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stop_on_fail(sof),
        .vec(vec_b), .impl_o(imp_b), .gold_o(gol_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .mismatch_cnt(mc_b), .first_fail(ff_b), .fail_seen(fs_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string t);
        chk({t, " vec_a"}, vec_a, 0);   chk({t, " vec_b"}, vec_b, 0);
        chk({t, " busy_a"}, busy_a, 0); chk({t, " busy_b"}, busy_b, 0);
        chk({t, " done_a"}, done_a, 0); chk({t, " done_b"}, done_b, 0);
        chk({t, " pass_a"}, pass_a, 0); chk({t, " pass_b"}, pass_b, 0);
        chk({t, " mc_a"}, mc_a, 0);     chk({t, " mc_b"}, mc_b, 0);
        chk({t, " ff_a"}, ff_a, 0);     chk({t, " ff_b"}, ff_b, 0);
        chk({t, " fs_a"}, fs_a, 0);     chk({t, " fs_b"}, fs_b, 0);
    endtask

    // Model: walk patterns in order, stopping at the abort point or at the first failure when asked
    task automatic check_dut(input string t, input int s_cyc, input int ab, input logic s,
                             input int nd, input int dd, input logic pd,
                             input logic [3:0] mc, input logic [2:0] ff, input logic fs,
                             input logic [2:0] v, input logic b, input logic p);
        int lim, n, emc, eff, efs;
        lim = ab < 0 ? 8 : ab / (s_cyc + 1);
        n = 0; emc = 0; eff = 0; efs = 0;
        for (int k = 0; k < lim; k++) begin
            logic m;
            m = tt_i[k] != tt_g[k];
            n++;
            if (m) begin
                emc++;
                if (efs == 0) begin eff = k; efs = 1; end
            end
            if (s && m) break;
        end
        if (ab < 0) begin
            chk({t, " done_count"}, nd, 1);
            chk({t, " done_cycle"}, dd, n * (s_cyc + 1) + 1);
            chk({t, " pass_at_done"}, pd, emc == 0);
            chk({t, " vec_end"}, v, n - 1);
            chk({t, " pass_held"}, p, emc == 0);
        end else begin
            chk({t, " no_done"}, nd, 0);
            chk({t, " vec_abort"}, v, n);
            chk({t, " pass_abort"}, p, 0);
        end
        chk({t, " mismatch_cnt"}, mc, emc);
        chk({t, " first_fail"}, ff, eff);
        chk({t, " fail_seen"}, fs, efs);
        chk({t, " busy_end"}, b, 0);
    endtask

    task automatic run(input string t, input logic [7:0] ti, input logic [7:0] tg,
                       input logic s, input int ab);
        int c0, d, nd_a, nd_b, dd_a, dd_b;
        logic pd_a, pd_b;
        nd_a = 0; nd_b = 0; dd_a = -1; dd_b = -1; pd_a = 1'bx; pd_b = 1'bx;
        tt_i = ti; tt_g = tg;
        @(negedge clk);
        start = 1'b1; sof = s; c0 = cyc;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            d = cyc - c0 - 1;
            if (done_a) begin nd_a++; dd_a = cyc - c0; pd_a = pass_a; end
            if (done_b) begin nd_b++; dd_b = cyc - c0; pd_b = pass_b; end
            if (k == 0) begin
                chk({t, " busy_a_start"}, busy_a, 1);
                chk({t, " busy_b_start"}, busy_b, 1);
            end
            if (ab >= 0 && d == ab + 1) begin
                chk({t, " busy_a_after_abort"}, busy_a, 0);
                chk({t, " busy_b_after_abort"}, busy_b, 0);
            end
            start = ab >= 0 && d == 1;
            abort = ab >= 0 && d == ab;
            sof   = $urandom_range(0, 1);
        end
        start = 1'b0; abort = 1'b0;
        check_dut({t, " A"}, 1, ab, s, nd_a, dd_a, pd_a, mc_a, ff_a, fs_a, vec_a, busy_a, pass_a);
        check_dut({t, " B"}, 3, ab, s, nd_b, dd_b, pd_b, mc_b, ff_b, fs_b, vec_b, busy_b, pass_b);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);
        run("ident", 8'hF8, 8'hF8, 1'b0, -1);
        run("or_ab", 8'hF8, 8'hFC, 1'b0, -1);
        run("or_ab_stop", 8'hF8, 8'hFC, 1'b1, -1);
        run("gold0", 8'hF8, 8'h00, 1'b0, -1);
        run("gold0_stop", 8'hF8, 8'h00, 1'b1, -1);
        run("abort6", 8'hF8, 8'hF8, 1'b0, 5);
        run("abort_late", 8'hF8, 8'h00, 1'b0, 15);
        for (int r = 0; r < 24; r++) begin
            logic [7:0] ti, tg;
            int ab;
            ti = 8'($urandom);
            tg = $urandom_range(0, 2) == 0 ? ti : 8'($urandom);
            ab = $urandom_range(0, 3) == 0 ? int'($urandom_range(2, 15)) : -1;
            run($sformatf("rnd%0d", r), ti, tg, ab < 0 ? 1'($urandom_range(0, 1)) : 1'b0, ab);
        end
        tt_i = 8'hFF; tt_g = 8'h00;
        @(negedge clk);
        start = 1'b1; sof = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run("post_reset", 8'hF8, 8'hF8, 1'b0, -1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
